wino_tile_feeder: RTL and testbench

- Input-side feeder for the Winograd F(2x2,3x3) datapath.
- Accepts a raster-order pixel stream of one feature-map channel and buffers it in a 4-row ring.
- Emits overlapping 4x4 data tiles at stride 2, one per handshake, to the data-transform input of the Winograd kernel top.
- Each tile produces one 2x2 output tile downstream.

---
 rtl/wino_tile_feeder.sv | 152 +++++++++++++++
 tb/tb_wino_tile_feeder.sv | 321 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wino_tile_feeder.sv
// Input-side feeder for the Winograd F(2x2,3x3) datapath: buffers a raster pixel
// stream in a 4-row ring and emits overlapping 4x4 tiles at stride 2.
module wino_tile_feeder #(
   parameter int WI    = 8,
   parameter int IMG_W = 8,
   parameter int IMG_H = 8
) (
   input  logic              clk,
   input  logic              rstn,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [WI-1:0]     in_pixel,
   output logic              tile_valid,
   input  logic              tile_ready,
   output logic [16*WI-1:0]  tile_data,
   output logic              tile_last
);

   localparam int CW = $clog2(IMG_W);
   localparam int RW = $clog2(IMG_H);
   localparam int TW = $clog2(IMG_W / 2);

   localparam logic [CW-1:0] LAST_COL = CW'(IMG_W - 1);
   localparam logic [RW-1:0] LAST_ROW = RW'(IMG_H - 1);
   localparam logic [TW-1:0] LAST_TC  = TW'(IMG_W / 2 - 2);

   typedef enum logic {
      LOAD = 1'b0,
      EMIT = 1'b1
   } state_t;

   state_t           state;
   logic [CW-1:0]    in_col;
   logic [RW-1:0]    in_row;
   logic [TW-1:0]    tile_col;

   logic [WI-1:0]    mem [4][IMG_W];

   logic             wr_en;
   logic             row_done;
   logic             band_done;
   logic             last_band;
   logic             tile_fire;
   logic [TW-1:0]    sel_tc;
   logic [16*WI-1:0] next_tile;
   logic [1:0]       slot;
   logic [CW-1:0]    col_idx;
   logic [WI-1:0]    pix;

   assign wr_en     = (state == LOAD) && in_valid && in_ready;
   assign row_done  = wr_en && (in_col == LAST_COL);
   assign band_done = in_row[0] && (in_row >= RW'(3));
   assign last_band = (in_row == LAST_ROW);
   assign tile_fire = (state == EMIT) && tile_valid && tile_ready;

   // Tile to load next: tile 0 of the band while filling, otherwise the following column pair.
   assign sel_tc = ((state == EMIT) && (tile_col != LAST_TC)) ? tile_col + TW'(1) : '0;

   // NOTE: every variable written here gets a value before any read, so no latch is inferred.
   always_comb begin
      next_tile = '0;
      slot      = '0;
      col_idx   = '0;
      pix       = '0;
      for (int i = 0; i < 4; i++) begin
         for (int j = 0; j < 4; j++) begin
            // Tile row i of band ending at row r lives in slot (r-3+i) mod 4 == (r+1+i) mod 4.
            slot    = in_row[1:0] + 2'(i + 1);
            col_idx = CW'(2 * int'(sel_tc) + j);
            pix     = mem[slot][col_idx];
            // The row-completing pixel is still being written; forward it.
            if (wr_en && (slot == in_row[1:0]) && (col_idx == in_col))
               pix = in_pixel;
            next_tile[(4*i+j)*WI +: WI] = pix;
         end
      end
   end

   // NOTE: the line buffer has no reset; every entry is written before it is read each frame.
   always_ff @(posedge clk) begin
      if (wr_en)
         mem[in_row[1:0]][in_col] <= in_pixel;
   end

   // NOTE: sequential state uses non-blocking assignments so all registers update together.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state      <= LOAD;
         in_col     <= '0;
         in_row     <= '0;
         tile_col   <= '0;
         in_ready   <= 1'b1;
         tile_valid <= 1'b0;
         tile_last  <= 1'b0;
         tile_data  <= '0;
      end else begin
         case (state)
            LOAD: begin
               if (wr_en) begin
                  if (row_done) begin
                     in_col <= '0;
                     if (band_done) begin
                        state      <= EMIT;
                        tile_col   <= '0;
                        in_ready   <= 1'b0;
                        tile_valid <= 1'b1;
                        tile_data  <= next_tile;
                        tile_last  <= last_band && (LAST_TC == '0);
                     end else begin
                        in_row <= in_row + RW'(1);
                     end
                  end else begin
                     in_col <= in_col + CW'(1);
                  end
               end
            end

            EMIT: begin
               if (tile_fire) begin
                  if (tile_col != LAST_TC) begin
                     tile_col  <= tile_col + TW'(1);
                     tile_data <= next_tile;
                     tile_last <= last_band && ((tile_col + TW'(1)) == LAST_TC);
                  end else begin
                     // Band finished: the next band needs only two new rows, a new frame needs four.
                     state      <= LOAD;
                     tile_col   <= '0;
                     tile_valid <= 1'b0;
                     tile_last  <= 1'b0;
                     in_ready   <= 1'b1;
                     in_row     <= last_band ? '0 : in_row + RW'(1);
                  end
               end
            end

            default: state <= LOAD;
         endcase
      end
   end

   property p_no_overlap;
      @(posedge clk) disable iff (!rstn) !(in_ready && tile_valid);
   endproperty
   a_no_overlap: assert property (p_no_overlap);

   property p_hold_under_stall;
      @(posedge clk) disable iff (!rstn)
         (tile_valid && !tile_ready) |=> (tile_valid && $stable(tile_data) && $stable(tile_last));
   endproperty
   a_hold_under_stall: assert property (p_hold_under_stall);

endmodule

// File: tb/tb_wino_tile_feeder.sv
// Self-checking bench for wino_tile_feeder: a frame-level tile model feeds a scoreboard
// that is compared against every delivered tile, plus literal pins of key tiles.
module tb_wino_tile_feeder;

   localparam int WI = 8;

   logic         clk = 1'b0;
   logic         rstn;
   logic         in_valid, in_ready, tile_valid, tile_ready, tile_last;
   logic [7:0]   in_pixel;
   logic [127:0] tile_data;

   logic         in_valid4, in_ready4, tile_valid4, tile_ready4, tile_last4;
   logic [7:0]   in_pixel4;
   logic [127:0] tile_data4;

   always #5 clk = ~clk;

   wino_tile_feeder #(.WI(WI), .IMG_W(8), .IMG_H(8)) dut8 (
      .clk(clk), .rstn(rstn),
      .in_valid(in_valid), .in_ready(in_ready), .in_pixel(in_pixel),
      .tile_valid(tile_valid), .tile_ready(tile_ready),
      .tile_data(tile_data), .tile_last(tile_last)
   );

   wino_tile_feeder #(.WI(WI), .IMG_W(4), .IMG_H(4)) dut4 (
      .clk(clk), .rstn(rstn),
      .in_valid(in_valid4), .in_ready(in_ready4), .in_pixel(in_pixel4),
      .tile_valid(tile_valid4), .tile_ready(tile_ready4),
      .tile_data(tile_data4), .tile_last(tile_last4)
   );

   typedef struct {
      logic [127:0] data;
      logic         last;
      logic         first;
   } exp_t;

   exp_t         exp_q[$];
   logic [127:0] cap[64];
   logic         cap_last[64];
   int           gidx = 0;
   int           vectors = 0;
   int           miscompares = 0;

   int stall_idx  = -1;
   int stall_left = 0;

   localparam logic [127:0] T0_LIT  = 128'h1b1a1918_13121110_0b0a0908_03020100;
   localparam logic [127:0] T1_LIT  = 128'h1d1c1b1a_15141312_0d0c0b0a_05040302;
   localparam logic [127:0] T3_LIT  = 128'h2b2a2928_23222120_1b1a1918_13121110;
   localparam logic [127:0] T8_LIT  = 128'h3f3e3d3c_37363534_2f2e2d2c_27262524;
   localparam logic [127:0] T9_LIT  = 128'h7f7e7d7c_77767574_6f6e6d6c_67666564;
   localparam logic [127:0] T4X4_LIT = 128'h0f0e0d0c_0b0a0908_07060504_03020100;

   task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
      vectors++;
      if (got !== exp) begin
         miscompares++;
         $display("FAIL %s: got %h expected %h", name, got, exp);
      end
   endtask

   task automatic fail_timeout(input string name);
      vectors++;
      miscompares++;
      $display("FAIL %s: timed out waiting, expected event never came", name);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   endtask

   // Model: every tile of an 8x8 frame is a 4x4 window of the image at (2b, 2tc).
   task automatic push_frame(input int base);
      int   img[8][8];
      exp_t t;
      for (int r = 0; r < 8; r++)
         for (int c = 0; c < 8; c++)
            img[r][c] = (base + 8 * r + c) & 8'hff;
      for (int b = 0; b < 3; b++) begin
         for (int tc = 0; tc < 3; tc++) begin
            t.data = '0;
            for (int i = 0; i < 4; i++)
               for (int j = 0; j < 4; j++)
                  t.data[(4*i+j)*8 +: 8] = 8'(img[2*b+i][2*tc+j]);
            t.last  = (b == 2) && (tc == 2);
            t.first = (b == 0) && (tc == 0);
            exp_q.push_back(t);
         end
      end
   endtask

   // Stall control for the downstream handshake.
   initial begin
      tile_ready = 1'b1;
      forever begin
         @(posedge clk);
         #1;
         if (stall_left > 0 && tile_valid && gidx == stall_idx) begin
            tile_ready = 1'b0;
            stall_left--;
         end else begin
            tile_ready = 1'b1;
         end
      end
   end

   // Compare process: outputs sampled on the falling edge, away from the active edge.
   logic         prev_stall, prev_tv, prev_last, last_acc;
   logic [127:0] prev_data;
   int           acc_cnt;
   exp_t         e;

   always @(negedge clk) begin
      if (!rstn) begin
         prev_stall = 1'b0;
         prev_tv    = 1'b0;
         last_acc   = 1'b0;
         acc_cnt    = 0;
      end else begin
         if (prev_stall) begin
            check("stall_valid_held", tile_valid, 1'b1);
            check("stall_data_held", tile_data, prev_data);
            check("stall_last_held", tile_last, prev_last);
         end
         check("in_ready_vs_valid", in_ready, !tile_valid);
         if (tile_valid && !prev_tv) begin
            check("fill_pixel_count", acc_cnt,
                  (exp_q.size() > 0 && exp_q[0].first) ? 32 : 16);
            check("valid_rise_latency", last_acc, 1'b1);
            acc_cnt = 0;
         end
         if (tile_valid && tile_ready) begin
            if (exp_q.size() == 0) begin
               check("unexpected_tile", 1'b1, 1'b0);
            end else begin
               e = exp_q.pop_front();
               check($sformatf("tile%0d_data", gidx), tile_data, e.data);
               check($sformatf("tile%0d_last", gidx), tile_last, e.last);
            end
            if (gidx < 64) begin
               cap[gidx]      = tile_data;
               cap_last[gidx] = tile_last;
            end
            gidx++;
         end
         prev_stall = tile_valid && !tile_ready;
         prev_data  = tile_data;
         prev_last  = tile_last;
         prev_tv    = tile_valid;
         last_acc   = in_valid && in_ready;
         if (last_acc) acc_cnt++;
      end
   end

   task automatic send_rows(input int base, input int nrows, input bit bubbles);
      bit acc;
      int n;
      for (int r = 0; r < nrows; r++) begin
         for (int c = 0; c < 8; c++) begin
            if (bubbles) begin
               repeat ($urandom_range(0, 2)) begin
                  in_valid = 1'b0;
                  @(posedge clk);
                  #1;
               end
            end
            in_valid = 1'b1;
            in_pixel = 8'(base + 8 * r + c);
            acc = 1'b0;
            n   = 0;
            while (!acc) begin
               @(negedge clk);
               acc = in_ready;
               @(posedge clk);
               #1;
               n++;
               if (n > 200) fail_timeout("pixel_accept");
            end
         end
      end
      in_valid = 1'b0;
   endtask

   task automatic wait_drain();
      int n = 0;
      while (exp_q.size() != 0 || tile_valid) begin
         @(posedge clk);
         #1;
         n++;
         if (n > 500) fail_timeout("tile_drain");
      end
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_tile_valid"}, tile_valid, 1'b0);
      check({tag, "_tile_last"}, tile_last, 1'b0);
      check({tag, "_tile_data"}, tile_data, '0);
      check({tag, "_in_ready"}, in_ready, 1'b1);
   endtask

   initial begin
      int  s;
      int  n;
      bit  acc;

      rstn        = 1'b0;
      in_valid    = 1'b0;
      in_pixel    = '0;
      in_valid4   = 1'b0;
      in_pixel4   = '0;
      tile_ready4 = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      check_reset_outputs("reset");
      check("reset4_in_ready", in_ready4, 1'b1);
      check("reset4_tile_valid", tile_valid4, 1'b0);
      rstn = 1'b1;
      @(posedge clk);
      #1;

      // Frame 1: plain stream, tile 4 held off for 5 cycles.
      s          = gidx;
      stall_idx  = s + 4;
      stall_left = 5;
      push_frame(0);
      send_rows(0, 8, 1'b0);
      wait_drain();
      check("f1_tile_count", gidx - s, 9);
      check("f1_tile0_lit", cap[s + 0], T0_LIT);
      check("f1_tile1_lit", cap[s + 1], T1_LIT);
      check("f1_tile3_lit", cap[s + 3], T3_LIT);
      check("f1_tile8_lit", cap[s + 8], T8_LIT);
      check("f1_tile8_last", cap_last[s + 8], 1'b1);
      check("f1_tile7_last", cap_last[s + 7], 1'b0);

      // Frame 2: random input bubbles, identical tile sequence expected.
      s = gidx;
      push_frame(0);
      send_rows(0, 8, 1'b1);
      wait_drain();
      check("f2_tile0_lit", cap[s + 0], T0_LIT);
      check("f2_tile8_lit", cap[s + 8], T8_LIT);

      // Frames 3-4: back-to-back with a different pixel base on the second.
      s = gidx;
      push_frame(0);
      send_rows(0, 8, 1'b0);
      push_frame(100);
      send_rows(100, 8, 1'b0);
      wait_drain();
      check("b2b_tile_count", gidx - s, 18);
      check("b2b_tile9_lit", cap[s + 9], T9_LIT);
      check("b2b_tile8_last", cap_last[s + 8], 1'b1);
      check("b2b_tile17_last", cap_last[s + 17], 1'b1);
      check("b2b_tile9_last", cap_last[s + 9], 1'b0);

      // Reset while tile 4 is stalled, then a clean frame.
      s          = gidx;
      push_frame(0);
      stall_idx  = s + 4;
      stall_left = 1000;
      send_rows(0, 6, 1'b0);
      n = 0;
      while (!(tile_valid && !tile_ready && gidx == s + 4)) begin
         @(negedge clk);
         n++;
         if (n > 300) fail_timeout("reach_tile4_stall");
      end
      #2;
      rstn = 1'b0;
      #1;
      check_reset_outputs("midemit_reset");
      exp_q.delete();
      stall_left = 0;
      @(posedge clk);
      @(posedge clk);
      #1;
      rstn = 1'b1;
      s = gidx;
      push_frame(0);
      send_rows(0, 8, 1'b0);
      wait_drain();
      check("post_reset_tile_count", gidx - s, 9);
      check("post_reset_tile0_lit", cap[s + 0], T0_LIT);

      // Minimum size instance: 4x4 frame gives exactly one, final, tile.
      for (int p = 0; p < 16; p++) begin
         in_valid4 = 1'b1;
         in_pixel4 = 8'(p);
         acc = 1'b0;
         n   = 0;
         while (!acc) begin
            @(negedge clk);
            acc = in_ready4;
            @(posedge clk);
            #1;
            n++;
            if (n > 50) fail_timeout("pixel4_accept");
         end
      end
      in_valid4 = 1'b0;
      @(negedge clk);
      check("min_tile_valid", tile_valid4, 1'b1);
      check("min_tile_data", tile_data4, T4X4_LIT);
      check("min_tile_last", tile_last4, 1'b1);
      check("min_in_ready_low", in_ready4, 1'b0);
      @(negedge clk);
      check("min_valid_drop", tile_valid4, 1'b0);
      check("min_in_ready_back", in_ready4, 1'b1);
      n = 0;
      repeat (5) begin
         @(negedge clk);
         if (tile_valid4) n++;
      end
      check("min_single_tile", n, 0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
